ov7670_config_sequencer: RTL and testbench

Reads the OV7670 register-initialisation ROM entry by entry and turns each entry into one SCCB register write. Consumer of the ROM's 16-bit word stream: upper byte is the register address, lower byte the value, 16'hFFF0 a settle delay, 16'hFFFF end of table. Sits between the config ROM and the SCCB write master in the camera bring-up path; `done` releases the capture pipeline.

---
 rtl/ov7670_cfg_pkg.sv | 19 +
 rtl/ov7670_config_sequencer.sv | 99 +++++++++
 tb/tb_ov7670_config_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_cfg_pkg.sv
// rtl/ov7670_cfg_pkg.sv - shared types and ROM markers for the OV7670 config sequencer
package ov7670_cfg_pkg;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;
    localparam int          ROM_AW    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_LO,
        WAIT_HI,
        DELAY,
        FINISH
    } state_t;

endpackage

// File: rtl/ov7670_config_sequencer.sv
// rtl/ov7670_config_sequencer.sv - walks the init ROM and issues one SCCB write per entry
module ov7670_config_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES = 250000,
    parameter int CNT_W        = $clog2(DELAY_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_en,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_data,
    input  logic              sccb_ready,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // The ROM only advances its output when enabled, so rom_data stays valid through DECODE.
    assign rom_en     = (state == FETCH);
    assign sccb_start = (state == SEND) && sccb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rom_addr  <= '0;
            sccb_reg  <= '0;
            sccb_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_data == ROM_END) begin
                        state <= FINISH;
                    end else if (rom_data == ROM_DELAY) begin
                        cnt   <= CNT_W'(DELAY_CYCLES - 1);
                        state <= DELAY;
                    end else begin
                        sccb_reg  <= rom_data[15:8];
                        sccb_data <= rom_data[7:0];
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (sccb_ready) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!sccb_ready) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (sccb_ready) begin
                        if (rom_addr == '1) begin
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        if (rom_addr == '1) begin
                            state <= FINISH;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb/tb_ov7670_config_sequencer.sv - directed bench for the OV7670 config sequencer
module tb_ov7670_config_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [15:0] rom_data = 16'h0000;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        busy;
    logic        done;

    logic        model_ready;
    int          model_cnt;
    logic        hold_low = 1'b0;
    logic [15:0] rom [256];

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_n = 0;
    int          en_n = 0;
    logic [7:0]  wr_reg [2048];
    logic [7:0]  wr_dat [2048];
    int          wr_cyc [2048];
    logic [7:0]  en_addr [2048];
    int          en_cyc [2048];

    always #5 clk = ~clk;

    assign sccb_ready = model_ready & ~hold_low;

    ov7670_config_sequencer #(.DELAY_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .sccb_start (sccb_start),
        .sccb_reg   (sccb_reg),
        .sccb_data  (sccb_data),
        .sccb_ready (sccb_ready),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    // SCCB master: ready low for 20 cycles starting the cycle after an accepted start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_ready <= 1'b1;
            model_cnt   <= 0;
        end else if (sccb_start && sccb_ready) begin
            model_ready <= 1'b0;
            model_cnt   <= 19;
        end else if (!model_ready) begin
            if (model_cnt == 0) model_ready <= 1'b1;
            else model_cnt <= model_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && sccb_start && wr_n < 2048) begin
            wr_reg[wr_n] = sccb_reg;
            wr_dat[wr_n] = sccb_data;
            wr_cyc[wr_n] = cyc;
            wr_n++;
        end
        if (rst_n && rom_en && en_n < 2048) begin
            en_addr[en_n] = rom_addr;
            en_cyc[en_n]  = cyc;
            en_n++;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rom_addr"}, {24'd0, rom_addr}, 32'd0);
        chk({tag, "_rom_en"}, {31'd0, rom_en}, 32'd0);
        chk({tag, "_sccb_start"}, {31'd0, sccb_start}, 32'd0);
        chk({tag, "_sccb_reg"}, {24'd0, sccb_reg}, 32'd0);
        chk({tag, "_sccb_data"}, {24'd0, sccb_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1100;
        rom[3] = 16'hFFFF;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_basic_run(input string tag, input int wb, input int eb);
        chk({tag, "_wr_count"}, wr_n - wb, 32'd2);
        chk({tag, "_wr0"}, {16'd0, wr_reg[wb], wr_dat[wb]}, 32'h1280);
        chk({tag, "_wr1"}, {16'd0, wr_reg[wb+1], wr_dat[wb+1]}, 32'h1100);
        chk({tag, "_en_count"}, en_n - eb, 32'd4);
        chk({tag, "_en_addr0"}, {24'd0, en_addr[eb]}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int wb, eb, bad, n;
        logic [7:0] b;

        load_basic();
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic table with start latency and delay spacing
        wb = wr_n; eb = en_n;
        pulse_start();
        chk("t1_fetch_en", {31'd0, rom_en}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_done_clr", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t1_decode_en", {31'd0, rom_en}, 32'd0);
        @(negedge clk);
        chk("t1_send_start", {31'd0, sccb_start}, 32'd1);
        chk("t1_send_reg", {24'd0, sccb_reg}, 32'h12);
        chk("t1_send_data", {24'd0, sccb_data}, 32'h80);
        wait_done(300, "t1_done");
        chk_basic_run("t1", wb, eb);
        chk("t1_refetch_gap", en_cyc[eb+1] - wr_cyc[wb], 32'd22);
        chk("t1_delay_gap", en_cyc[eb+2] - en_cyc[eb+1], 32'd6);

        // Start during busy is ignored; start after done restarts from 0
        wb = wr_n; eb = en_n;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(300, "t2_done");
        chk_basic_run("t2", wb, eb);
        pulse_start();
        chk("t2_restart_done", {31'd0, done}, 32'd0);
        chk("t2_restart_addr", {24'd0, rom_addr}, 32'd0);
        chk("t2_restart_busy", {31'd0, busy}, 32'd1);
        wait_done(300, "t2_done2");

        // First entry is end-of-table
        rom[0] = 16'hFFFF;
        wb = wr_n;
        pulse_start();
        @(negedge clk);
        chk("t3_decode_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t3_finish_done", {31'd0, done}, 32'd0);
        chk("t3_finish_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t3_k2_done", {31'd0, done}, 32'd1);
        chk("t3_k2_busy", {31'd0, busy}, 32'd0);
        chk("t3_no_write", wr_n - wb, 32'd0);

        // SCCB master busy at SEND
        rom[0] = 16'h1280;
        rom[1] = 16'hFFFF;
        hold_low = 1'b1;
        wb = wr_n;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (sccb_start !== 1'b0 || sccb_reg !== 8'h12 || sccb_data !== 8'h80) bad++;
            @(negedge clk);
        end
        chk("t4_hold_stable", bad, 32'd0);
        hold_low = 1'b0;
        #1;
        chk("t4_release_start", {31'd0, sccb_start}, 32'd1);
        wait_done(300, "t4_done");
        chk("t4_single_write", wr_n - wb, 32'd1);

        // 256 ordinary entries, no terminator
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            rom[i] = {b, ~b};
        end
        wb = wr_n; eb = en_n;
        pulse_start();
        wait_done(8000, "t5_done");
        chk("t5_wr_count", wr_n - wb, 32'd256);
        chk("t5_en_count", en_n - eb, 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            if (wr_reg[wb+i] !== b || wr_dat[wb+i] !== ~b) bad++;
        end
        chk("t5_wr_values", bad, 32'd0);
        chk("t5_no_wrap", {24'd0, rom_addr}, 32'd255);

        // Reset during WAIT_HI
        load_basic();
        wb = wr_n;
        pulse_start();
        n = 0;
        while (wr_n == wb && n < 100) begin @(negedge clk); n++; end
        chk("t6_first_write", wr_n - wb, 32'd1);
        repeat (5) @(negedge clk);
        do_reset();
        chk_reset("t6_rst_waithi");
        rst_n = 1'b1;

        // Reset during DELAY
        eb = en_n;
        pulse_start();
        n = 0;
        while (en_n - eb < 2 && n < 100) begin @(negedge clk); n++; end
        chk("t6_second_fetch", en_n - eb, 32'd2);
        @(negedge clk);
        do_reset();
        chk_reset("t6_rst_delay");
        rst_n = 1'b1;

        wb = wr_n; eb = en_n;
        pulse_start();
        wait_done(300, "t6_done");
        chk_basic_run("t6", wb, eb);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
